pio_in_edge_irq: RTL and testbench

// - Parametrised Avalon-MM input PIO for the SOPC: next generation of the read-only data port.
// - Synchronises an asynchronous WIDTH-bit input bus, optionally debounces it, and captures per-bit edges.
// - Raises a maskable level interrupt to the CPU; sits between board inputs (keys/switches) and the Avalon fabric.

---
 rtl/pio_in_edge_irq.sv | 132 +++++++++++++
 tb/tb_pio_in_edge_irq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with synchroniser, edge capture, irq.
// Optional debounce filter is built when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_edge_irq #(
   parameter int WIDTH           = 32,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int DB_EN = 1;
`else
   localparam int DB_EN = 0;
`endif
   localparam int WU_INIT = SYNC_STAGES + 1 + DB_EN * DEBOUNCE_CYCLES;
   localparam int WU_W    = $clog2(WU_INIT + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_filt;
   logic [WIDTH-1:0] r_prev;
   logic [WU_W-1:0]  r_warm;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] r_cap;
   logic [WIDTH-1:0] r_mask;
   logic [31:0]      w_rd;
   logic             w_unused_wd;

   // Upper writedata bits are ignored when WIDTH < 32.
   assign w_unused_wd = ^writedata;

   // Shift each input bit through the synchroniser chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [WIDTH-1:0][CW-1:0] r_cnt;
   logic [WIDTH-1:0]         r_filt;

   // Toggle a filtered bit only after it disagreed long enough.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_filt <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (w_sync[i] == r_filt[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_cnt[i]  <= '0;
               r_filt[i] <= ~r_filt[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign w_filt = r_filt;
`else
   assign w_filt = w_sync;
`endif

   // Track the previous filtered value and count down the warm-up.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= '0;
         r_warm <= WU_W'(WU_INIT);
      end else begin
         r_prev <= w_filt;
         if (r_warm != '0) r_warm <= r_warm - WU_W'(1);
      end
   end

   // Select the edge polarity; nothing is detected during warm-up.
   always_comb begin
      w_edge = '0;
      if (EDGE_TYPE == 0)      w_edge = w_filt & ~r_prev;
      else if (EDGE_TYPE == 1) w_edge = ~w_filt & r_prev;
      else                     w_edge = w_filt ^ r_prev;
      if (r_warm != '0) w_edge = '0;
   end

   assign w_clr = (write && address == 2'd2) ? writedata[WIDTH-1:0] : '0;

   // Capture edges; a new edge beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_cap <= '0;
      else          r_cap <= (r_cap & ~w_clr) | w_edge;
   end

   // Interrupt mask register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        r_mask <= '0;
      else if (write && address == 2'd1)   r_mask <= writedata[WIDTH-1:0];
   end

   // Read mux, zero-extended to the bus width.
   always_comb begin
      w_rd = '0;
      unique case (address)
         2'd0:    w_rd[WIDTH-1:0] = w_filt;
         2'd1:    w_rd[WIDTH-1:0] = r_mask;
         2'd2:    w_rd[WIDTH-1:0] = r_cap;
         default: w_rd = '0;
      endcase
   end

   // Registered read data, reloaded every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= w_rd;
   end

   assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: three DUTs (rise/fall/any) against a queue-based model.
// Directed steps plus random traffic; honours PIO_IN_DEBOUNCE_EN.
module tb_pio_in_edge_irq;

   localparam int W = 8;
   localparam int S = 2;
   localparam int D = 4;
`ifdef PIO_IN_DEBOUNCE_EN
   localparam int DBL = D;
`else
   localparam int DBL = 0;
`endif
   localparam int LAT = S + DBL;
   localparam int WU  = S + 1 + DBL;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [1:0]   address;
   logic         write;
   logic [31:0]  writedata;
   logic [W-1:0] in_port;
   logic [31:0]  rd [3];
   logic         irqv [3];

   int n_assert = 0;
   int n_fail   = 0;

   logic [W-1:0] q[$];
   logic [W-1:0] m_filt, m_prev, m_mask;
   logic [W-1:0] m_cap [3];
   logic [31:0]  m_rd [3];
   logic         m_irq [3];
   int           m_n;
   int           m_run [W];

   always #5 clk = ~clk;

   pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0),
      .DEBOUNCE_CYCLES(D)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .write(write),
      .writedata(writedata), .in_port(in_port),
      .readdata(rd[0]), .irq(irqv[0]));

   pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(1),
      .DEBOUNCE_CYCLES(D)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .write(write),
      .writedata(writedata), .in_port(in_port),
      .readdata(rd[1]), .irq(irqv[1]));

   pio_in_edge_irq #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2),
      .DEBOUNCE_CYCLES(D)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .write(write),
      .writedata(writedata), .in_port(in_port),
      .readdata(rd[2]), .irq(irqv[2]));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < S; i++) q.push_back('0);
      m_filt = '0;
      m_prev = '0;
      m_mask = '0;
      m_n    = 0;
      for (int t = 0; t < 3; t++) begin
         m_cap[t] = '0;
         m_rd[t]  = '0;
         m_irq[t] = 1'b0;
      end
      for (int b = 0; b < W; b++) m_run[b] = 0;
   endtask

   // One clock edge of the reference, from the current inputs.
   task automatic model_edge();
      logic [W-1:0] ed, clr;
      m_n++;
      clr = (write && address == 2'd2) ? writedata[W-1:0] : '0;
      for (int t = 0; t < 3; t++) begin
         case (t)
            0:       ed = m_filt & ~m_prev;
            1:       ed = ~m_filt & m_prev;
            default: ed = m_filt ^ m_prev;
         endcase
         if (m_n <= WU) ed = '0;
         case (address)
            2'd0:    m_rd[t] = 32'(m_filt);
            2'd1:    m_rd[t] = 32'(m_mask);
            2'd2:    m_rd[t] = 32'(m_cap[t]);
            default: m_rd[t] = '0;
         endcase
         m_cap[t] = (m_cap[t] & ~clr) | ed;
      end
      if (write && address == 2'd1) m_mask = writedata[W-1:0];
      m_prev = m_filt;
`ifdef PIO_IN_DEBOUNCE_EN
      for (int b = 0; b < W; b++) begin
         if (q[0][b] != m_filt[b]) begin
            m_run[b]++;
            if (m_run[b] == D) begin
               m_filt[b] = ~m_filt[b];
               m_run[b]  = 0;
            end
         end else begin
            m_run[b] = 0;
         end
      end
      q.push_back(in_port);
      void'(q.pop_front());
`else
      q.push_back(in_port);
      void'(q.pop_front());
      m_filt = q[0];
`endif
      for (int t = 0; t < 3; t++) m_irq[t] = |(m_cap[t] & m_mask);
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      for (int t = 0; t < 3; t++) begin
         chk($sformatf("%s rd%0d", tag, t), rd[t], m_rd[t]);
         chk($sformatf("%s irq%0d", tag, t), 32'(irqv[t]), 32'(m_irq[t]));
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address   = a;
      write     = 1'b1;
      writedata = d;
      tick("wr");
      write     = 1'b0;
   endtask

   task automatic settle(input string tag);
      repeat (LAT + 2) tick(tag);
   endtask

   initial begin
      reset_n   = 1'b0;
      address   = 2'd2;
      write     = 1'b0;
      writedata = '0;
      in_port   = 8'hFF;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("in_reset rd", rd[0], 32'h0);
      chk("in_reset irq", 32'(irqv[0]), 32'h0);
      reset_n = 1'b1;
      chk("release rd", rd[0], 32'h0);
      repeat (LAT + 4) tick("hold_high");
      chk("hold_high cap", rd[0], 32'h0);
      chk("hold_high cap any", rd[2], 32'h0);
      address = 2'd1;
      tick("rd_mask");
      chk("reset mask", rd[0], 32'h0);
      address = 2'd3;
      tick("rd_rsvd");
      chk("reserved", rd[0], 32'h0);
      address = 2'd0;
      tick("rd_data");
      chk("data ff", rd[0], 32'hFF);

      in_port = 8'h00;
      settle("to_zero");
      wr(2'd2, 32'hFF);
      wr(2'd0, 32'hFF);
      wr(2'd3, 32'hFF);
      in_port = 8'hA5;
      address = 2'd0;
      repeat (LAT) tick("data_lat");
      chk("data early", rd[0], 32'h0);
      tick("data_lat");
      chk("data a5", rd[0], 32'hA5);

      in_port = 8'h00;
      settle("clr_in");
      wr(2'd2, 32'hFFFF_FFFF);
      wr(2'd1, 32'h0000_0101);
      address = 2'd1;
      tick("mask_rd");
      chk("mask upper bits", rd[0], 32'h01);
      address = 2'd2;
      chk("irq idle", 32'(irqv[0]), 32'h0);
      in_port = 8'h01;
      repeat (LAT) tick("edge");
      chk("irq before cap", 32'(irqv[0]), 32'h0);
      tick("edge");
      chk("irq on cap", 32'(irqv[0]), 32'h1);
      tick("edge");
      chk("cap bit0", rd[0], 32'h01);
      wr(2'd2, 32'h01);
      chk("irq cleared", 32'(irqv[0]), 32'h0);

      in_port = 8'h00;
      settle("coll_low");
      in_port = 8'h01;
      repeat (LAT) tick("coll");
      wr(2'd2, 32'h01);
      chk("coll irq", 32'(irqv[0]), 32'h1);
      tick("coll");
      chk("coll cap", rd[0], 32'h01);
      wr(2'd2, 32'hFF);
      in_port = 8'h00;
      settle("fall");
      chk("fall rise-dut", rd[0], 32'h0);
      chk("fall fall-dut", rd[1], 32'h01);
      chk("fall any-dut", rd[2], 32'h01);

      wr(2'd1, 32'h0);
      in_port = 8'h02;
      settle("unmask");
      chk("masked irq", 32'(irqv[0]), 32'h0);
      wr(2'd1, 32'h02);
      chk("unmask irq", 32'(irqv[0]), 32'h1);

      in_port = 8'h06;
      repeat (3) tick("pulse");
      in_port = 8'h02;
      repeat (LAT + 4) tick("pulse");
      in_port = 8'h06;
      repeat (6 + LAT) tick("long");
      address = 2'd0;
      tick("long");
      chk("long data", rd[0], 32'h06);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) in_port ^= W'($urandom);
         address = 2'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            write     = 1'b1;
            writedata = $urandom;
         end
         tick("rand");
         write = 1'b0;
      end

      in_port = 8'h00;
      settle("mid_pre");
      wr(2'd2, 32'hFF);
      wr(2'd1, 32'hFF);
      in_port = 8'h0F;
      address = 2'd2;
      settle("mid_cap");
      chk("mid cap", rd[0], 32'h0F);
      chk("mid irq", 32'(irqv[0]), 32'h1);
      reset_n = 1'b0;
      #1;
      for (int t = 0; t < 3; t++) begin
         chk($sformatf("mid_rst rd%0d", t), rd[t], 32'h0);
         chk($sformatf("mid_rst irq%0d", t), 32'(irqv[t]), 32'h0);
      end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      address = 2'd1;
      tick("post_rst");
      chk("post_rst mask", rd[0], 32'h0);
      address = 2'd2;
      repeat (LAT + 3) tick("post_rst");
      chk("post_rst cap", rd[0], 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
